// File: rtl/ym3438_phase_decoder.sv
// ---------------------------------------------------------------------------
// ym3438_phase_decoder
//
// Consumer side of the chip-clock prescaler. The two-phase chip clocks c1/c2
// arrive as plain levels in the MCLK domain. This block turns them into
// single-cycle edge strobes, keeps the 24-slot sequencer used by the
// operator, envelope and channel pipelines, measures the c1 period and
// reports whether that period has been stable long enough to be trusted.
//
// Ports
//   MCLK         master clock, all state changes on its rising edge
//   IC           asynchronous active-low initial clear
//   c1, c2       phase-1 / phase-2 chip clock levels (MCLK domain)
//   reset_fsm    slot-counter reset request, only looked at on a c1 rise
//   c1_pulse     one-MCLK strobe per c1 rising edge
//   c2_pulse     one-MCLK strobe per c2 rising edge
//   slot         current slot index 0..SLOTS-1
//   sync         one-MCLK strobe with c1_pulse whenever slot becomes 0
//   period       MCLK cycles between the last two c1 rises (saturating)
//   locked       c1 period has repeated LOCK_CYCLES times with no overlap
//   overlap_err  sticky flag: c1 and c2 were seen high together
// ---------------------------------------------------------------------------
module ym3438_phase_decoder #(
  parameter int SLOTS       = 24,
  parameter int LOCK_CYCLES = 4,
  parameter int PER_W       = 8
) (
  input  logic             MCLK,
  input  logic             IC,
  input  logic             c1,
  input  logic             c2,
  input  logic             reset_fsm,
  output logic             c1_pulse,
  output logic             c2_pulse,
  output logic [4:0]       slot,
  output logic             sync,
  output logic [PER_W-1:0] period,
  output logic             locked,
  output logic             overlap_err
);

  localparam int               MATCH_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [PER_W-1:0] PER_MAX    = {PER_W{1'b1}};
  localparam logic [4:0]       SLOT_LAST  = 5'(SLOTS - 1);
  localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_CYCLES);

  // Saturating increment of a period-width count.
  function automatic logic [PER_W-1:0] per_sat_inc(input logic [PER_W-1:0] v);
    return (v == PER_MAX) ? PER_MAX : v + PER_W'(1);
  endfunction

  // Match counter stops at LOCK_CYCLES so it never wraps back below lock.
  function automatic logic [MATCH_W-1:0] match_sat_inc(input logic [MATCH_W-1:0] v);
    return (v == MATCH_FULL) ? MATCH_FULL : v + MATCH_W'(1);
  endfunction

  // Registered state.
  logic               c1_q, c2_q;
  logic               c1_pulse_q, c2_pulse_q;
  logic [4:0]         slot_q;
  logic               sync_q;
  logic [PER_W-1:0]   per_cnt_q;
  logic [PER_W-1:0]   period_q;
  logic [PER_W-1:0]   prev_period_q;
  logic [MATCH_W-1:0] match_cnt_q;
  logic               locked_q;
  logic               overlap_err_q;
  logic               ovl_since_rise_q;
  logic               seen_rise_q;
  logic               have_prev_q;

  // Next-state values.
  logic               c1_d, c2_d;
  logic               c1_pulse_d, c2_pulse_d;
  logic [4:0]         slot_d;
  logic               sync_d;
  logic [PER_W-1:0]   per_cnt_d;
  logic [PER_W-1:0]   period_d;
  logic [PER_W-1:0]   prev_period_d;
  logic [MATCH_W-1:0] match_cnt_d;
  logic               locked_d;
  logic               overlap_err_d;
  logic               ovl_since_rise_d;
  logic               seen_rise_d;
  logic               have_prev_d;

  // Edge and event detection on the sampled levels.
  logic             rise1, rise2;
  logic             overlap_now;
  logic [PER_W-1:0] meas;
  logic [4:0]       slot_next;

  assign rise1       = c1 & ~c1_q;
  assign rise2       = c2 & ~c2_q;
  // Judged on the registered copies so a glitch between samples is ignored.
  assign overlap_now = c1_q & c2_q;
  // per_cnt is cleared on the rise edge itself, so the interval is count+1.
  assign meas        = per_sat_inc(per_cnt_q);
  assign slot_next   = (slot_q == SLOT_LAST) ? 5'd0 : slot_q + 5'd1;

  always_comb begin
    c1_d             = c1;
    c2_d             = c2;
    c1_pulse_d       = rise1;
    c2_pulse_d       = rise2;
    slot_d           = slot_q;
    sync_d           = 1'b0;
    per_cnt_d        = per_cnt_q;
    period_d         = period_q;
    prev_period_d    = prev_period_q;
    match_cnt_d      = match_cnt_q;
    overlap_err_d    = overlap_err_q;
    ovl_since_rise_d = ovl_since_rise_q;
    seen_rise_d      = seen_rise_q;
    have_prev_d      = have_prev_q;

    if (rise1) begin
      // A reset request coinciding with the wrap still yields one sync,
      // since both paths land on slot 0 in the same edge.
      slot_d           = reset_fsm ? 5'd0 : slot_next;
      sync_d           = (slot_d == 5'd0);
      per_cnt_d        = '0;
      ovl_since_rise_d = 1'b0;

      if (!seen_rise_q) begin
        // The count since reset is not a real period; just arm measurement.
        seen_rise_d = 1'b1;
      end else begin
        period_d = meas;
        if (have_prev_q && (meas == prev_period_q) && (meas != PER_MAX) &&
            !ovl_since_rise_q) begin
          match_cnt_d = match_sat_inc(match_cnt_q);
        end else begin
          match_cnt_d = '0;
        end
        prev_period_d = meas;
        have_prev_d   = 1'b1;
      end
    end else begin
      per_cnt_d = per_sat_inc(per_cnt_q);
      // A counter pinned at its ceiling means c1 has stopped or slowed
      // beyond measurement; drop lock rather than trusting the old period.
      if (per_cnt_d == PER_MAX) begin
        match_cnt_d = '0;
      end
    end

    // Overlap overrides every other lock update on the same edge.
    if (overlap_now) begin
      overlap_err_d    = 1'b1;
      ovl_since_rise_d = 1'b1;
      match_cnt_d      = '0;
    end

    locked_d = (match_cnt_d == MATCH_FULL);
  end

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      c1_q             <= 1'b0;
      c2_q             <= 1'b0;
      c1_pulse_q       <= 1'b0;
      c2_pulse_q       <= 1'b0;
      slot_q           <= 5'd0;
      sync_q           <= 1'b0;
      per_cnt_q        <= '0;
      period_q         <= '0;
      prev_period_q    <= '0;
      match_cnt_q      <= '0;
      locked_q         <= 1'b0;
      overlap_err_q    <= 1'b0;
      ovl_since_rise_q <= 1'b0;
      seen_rise_q      <= 1'b0;
      have_prev_q      <= 1'b0;
    end else begin
      c1_q             <= c1_d;
      c2_q             <= c2_d;
      c1_pulse_q       <= c1_pulse_d;
      c2_pulse_q       <= c2_pulse_d;
      slot_q           <= slot_d;
      sync_q           <= sync_d;
      per_cnt_q        <= per_cnt_d;
      period_q         <= period_d;
      prev_period_q    <= prev_period_d;
      match_cnt_q      <= match_cnt_d;
      locked_q         <= locked_d;
      overlap_err_q    <= overlap_err_d;
      ovl_since_rise_q <= ovl_since_rise_d;
      seen_rise_q      <= seen_rise_d;
      have_prev_q      <= have_prev_d;
    end
  end

  assign c1_pulse    = c1_pulse_q;
  assign c2_pulse    = c2_pulse_q;
  assign slot        = slot_q;
  assign sync        = sync_q;
  assign period      = period_q;
  assign locked      = locked_q;
  assign overlap_err = overlap_err_q;

endmodule

// File: tb/tb_ym3438_phase_decoder.sv
// ---------------------------------------------------------------------------
// tb_ym3438_phase_decoder
//
// Drives ym3438_phase_decoder with directed chip-clock patterns followed by
// randomized ones, and compares every output on every clock against a
// reference model built on rise timestamps and a history of measured
// periods.
// ---------------------------------------------------------------------------
module tb_ym3438_phase_decoder;

  localparam int SLOTS = 24;
  localparam int LOCK  = 4;
  localparam int PER_W = 8;
  localparam int PMAX  = 255;

  logic             MCLK = 1'b0;
  logic             IC = 1'b0;
  logic             c1 = 1'b0;
  logic             c2 = 1'b0;
  logic             reset_fsm = 1'b0;
  logic             c1_pulse, c2_pulse, sync, locked, overlap_err;
  logic [4:0]       slot;
  logic [PER_W-1:0] period;

  int vecs = 0;
  int miss = 0;

  always #5 MCLK = ~MCLK;

  ym3438_phase_decoder #(.SLOTS(SLOTS), .LOCK_CYCLES(LOCK), .PER_W(PER_W)) dut (
    .MCLK(MCLK), .IC(IC), .c1(c1), .c2(c2), .reset_fsm(reset_fsm),
    .c1_pulse(c1_pulse), .c2_pulse(c2_pulse), .slot(slot), .sync(sync),
    .period(period), .locked(locked), .overlap_err(overlap_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  n_edge;
  bit  m_c1p, m_c2p;
  bit  m_seen;
  int  m_last_rise;
  int  m_slot;
  int  m_meas[$];
  bit  m_clean[$];
  bit  m_ovl_int, m_dist, m_sticky;
  bit  e_c1p, e_c2p, e_sync, e_locked;
  int  e_period;

  task automatic model_clear();
    m_c1p = 0; m_c2p = 0; m_seen = 0; m_last_rise = 0; m_slot = 0;
    m_meas.delete(); m_clean.delete();
    m_ovl_int = 0; m_dist = 0; m_sticky = 0;
    e_c1p = 0; e_c2p = 0; e_sync = 0; e_locked = 0; e_period = 0;
  endtask

  task automatic model_step();
    bit r1, r2, ov;
    int meas, sz;
    r1 = c1 && !m_c1p;
    r2 = c2 && !m_c2p;
    ov = m_c1p && m_c2p;
    e_c1p  = r1;
    e_c2p  = r2;
    e_sync = 0;
    if (r1) begin
      m_slot = reset_fsm ? 0 : (m_slot + 1) % SLOTS;
      e_sync = (m_slot == 0);
      if (m_seen) begin
        meas = n_edge - m_last_rise;
        if (meas > PMAX) meas = PMAX;
        m_meas.push_back(meas);
        m_clean.push_back(!m_ovl_int);
        e_period = meas;
        m_dist = 0;
      end
      m_seen = 1;
      m_last_rise = n_edge;
      m_ovl_int = 0;
    end else if (m_seen && (n_edge - m_last_rise) >= PMAX) begin
      m_dist = 1;
    end
    if (ov) begin
      m_ovl_int = 1; m_dist = 1; m_sticky = 1;
    end
    while (m_meas.size() > LOCK + 1) begin
      void'(m_meas.pop_front());
      void'(m_clean.pop_front());
    end
    // Locked: the last LOCK+1 periods are equal and measurable, the last
    // LOCK intervals were overlap-free, and nothing has disturbed it since.
    sz = m_meas.size();
    e_locked = 0;
    if (sz >= LOCK + 1 && !m_dist && m_meas[sz-1] < PMAX) begin
      e_locked = 1;
      for (int i = sz - LOCK - 1; i < sz; i++) if (m_meas[i] != m_meas[sz-1]) e_locked = 0;
      for (int i = sz - LOCK; i < sz; i++) if (!m_clean[i]) e_locked = 0;
    end
    m_c1p = c1;
    m_c2p = c2;
    n_edge++;
  endtask

  initial begin : compare
    n_edge = 0;
    model_clear();
    forever begin
      @(posedge MCLK);
      if (!IC) begin
        model_clear();
      end else begin
        model_step();
        #1;
        if (IC) begin
          chk("c1_pulse", c1_pulse, e_c1p);
          chk("c2_pulse", c2_pulse, e_c2p);
          chk("slot", slot, m_slot);
          chk("sync", sync, e_sync);
          chk("period", period, e_period);
          chk("locked", locked, e_locked);
          chk("overlap_err", overlap_err, m_sticky);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Applies one input vector at the current falling edge and holds it for a
  // full cycle, returning at the next falling edge.
  task automatic drive(input bit a, input bit b, input bit rf);
    c1 = a; c2 = b; reset_fsm = rf;
    @(negedge MCLK);
  endtask

  // c1 high on phases 0,1; c2 high on phases 3,4. ovl_idx selects a period
  // in which c2 is also raised on phase 1 to create an overlap.
  task automatic run_periods(input int per, input int nper, input bit rf_first, input int ovl_idx);
    for (int p = 0; p < nper; p++)
      for (int ph = 0; ph < per; ph++)
        drive(ph < 2, ((ph >= 3) && (ph <= 4)) || ((p == ovl_idx) && (ph == 1)),
              (p == 0) && (ph == 0) && rf_first);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_c1_pulse"}, c1_pulse, 0);
    chk({tag, "_c2_pulse"}, c2_pulse, 0);
    chk({tag, "_slot"}, slot, 0);
    chk({tag, "_sync"}, sync, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_overlap_err"}, overlap_err, 0);
  endtask

  initial begin : stim
    int per;
    @(negedge MCLK);
    repeat (3) @(negedge MCLK);
    chk_all_zero("reset");
    IC = 1'b1;

    // Period-6 lock acquisition.
    run_periods(6, 5, 0, -1);
    chk("t1_unlocked_rise5", locked, 0);
    chk("t1_period_rise5", period, 6);
    run_periods(6, 1, 0, -1);
    chk("t1_locked_rise6", locked, 1);
    chk("t1_period", period, 6);
    chk("t1_overlap", overlap_err, 0);
    chk("t1_slot", slot, 6);

    // Slot reset and wrap.
    run_periods(6, 1, 1, -1);
    chk("t2_slot_reset", slot, 0);
    run_periods(6, 23, 0, -1);
    chk("t2_slot23", slot, 23);
    run_periods(6, 1, 0, -1);
    chk("t2_slot_wrap", slot, 0);
    chk("t2_still_locked", locked, 1);

    // Overlap while locked.
    run_periods(6, 1, 0, 0);
    chk("t3_overlap_set", overlap_err, 1);
    chk("t3_lock_lost", locked, 0);
    run_periods(6, 4, 0, -1);
    chk("t3_not_yet", locked, 0);
    chk("t3_sticky", overlap_err, 1);
    run_periods(6, 1, 0, -1);
    chk("t3_relocked", locked, 1);

    // Period change 6 -> 7.
    run_periods(7, 2, 0, -1);
    chk("t4_period7", period, 7);
    chk("t4_unlocked", locked, 0);
    run_periods(7, 3, 0, -1);
    chk("t4_not_yet", locked, 0);
    run_periods(7, 1, 0, -1);
    chk("t4_relocked", locked, 1);
    chk("t4_slot", slot, 12);

    // Stopped c1.
    repeat (200) drive(0, 0, 0);
    chk("t5_hold_locked", locked, 1);
    repeat (60) drive(0, 0, 0);
    chk("t5_sat_unlocked", locked, 0);
    chk("t5_slot_frozen", slot, 12);
    chk("t5_period_kept", period, 7);

    // Reach slot 13 locked, then asynchronous clear mid-slot.
    run_periods(6, 1, 1, -1);
    chk("t6_slot0", slot, 0);
    chk("t6_sat_period", period, 255);
    run_periods(6, 13, 0, -1);
    chk("t6_slot13", slot, 13);
    chk("t6_locked", locked, 1);
    drive(1, 0, 0);
    #2 IC = 1'b0;
    #1 chk_all_zero("async_clear");
    @(negedge MCLK);
    c1 = 0; c2 = 0;
    @(negedge MCLK);
    IC = 1'b1;
    run_periods(6, 1, 0, -1);
    chk("t6_first_slot", slot, 1);
    chk("t6_first_period", period, 0);

    // Randomized chip-clock patterns.
    per = 6;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) per = $urandom_range(4, 12);
      run_periods(per, 1, $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 9) == 0) ? 0 : -1);
    end
    repeat (300) drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
